// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the PA-RISC pipeline sequencing controller.
//   fwd_t   : operand source select encodings (RF / EX / MEM / WB)
//   state_t : sequencing FSM states (RUN / MEM_WAIT)
//   REG_ZERO: hard-wired zero register GR0, which never forwards or hazards
package pa_risc_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus between the datapath stages and hazard_ctrl.
//   Inputs to the controller : ID source regs/uses, EX/MEM/WB destination
//                              regs and write enables, EX load flag, MEM RAM
//                              request, EX branch taken and nullify bit.
//   Outputs of the controller: forwarding selects, PC / IF/ID / pipe load
//                              enables, IF/ID clear, ID NOP insert, TA select.
//   master: the pipeline side (drives stage info, consumes controls)
//   slave : the controller side
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_rf_le;
    logic       ex_l;
    logic [4:0] mem_rd;
    logic       mem_rf_le;
    logic [4:0] wb_rd;
    logic       wb_rf_le;
    logic       mem_req;
    logic       ex_br_taken;
    logic       ex_nullify;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       pc_le;
    logic       ifid_le;
    logic       ifid_clr;
    logic       id_nop;
    logic       pipe_le;
    logic       pc_sel_ta;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_rf_le, ex_l, mem_rd, mem_rf_le, wb_rd, wb_rf_le,
               mem_req, ex_br_taken, ex_nullify,
        input  fwd_a, fwd_b, pc_le, ifid_le, ifid_clr, id_nop, pipe_le, pc_sel_ta
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_rf_le, ex_l, mem_rd, mem_rf_le, wb_rd, wb_rf_le,
               mem_req, ex_br_taken, ex_nullify,
        output fwd_a, fwd_b, pc_le, ifid_le, ifid_clr, id_nop, pipe_le, pc_sel_ta
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one ID source operand.
//   rs, rs_used        : ID source register and whether it is read
//   ex_/mem_/wb_ rd/le : destination register and RF write enable per stage
//   ex_l               : EX holds a load (its data is not ready in EX)
//   sel                : 00 RF, 01 EX ALU_Out, 10 MEM result, 11 WB PD
module fwd_sel
    import pa_risc_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       rs_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_le,
    input  logic       ex_l,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_le,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_le,
    output logic [1:0] sel
);
    // Youngest producer wins; GR0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (rs_used && rs != REG_ZERO) begin
            if (ex_rf_le && !ex_l && ex_rd == rs)
                sel = FWD_EX;
            else if (mem_rf_le && mem_rd == rs)
                sel = FWD_MEM;
            else if (wb_rf_le && wb_rd == rs)
                sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage PA-RISC core.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   hif        : hazard bus (slave side), see hazard_ctrl_if
//   MEM_LAT    : data-RAM latency (1..15); a RAM access freezes MEM_LAT-1 cycles
//   CNT_W      : performance counter width
// Optional macro HAZARD_PERF_CNT_EN adds saturating counters
//   stall_cnt (load-use bubbles), freeze_cnt (frozen cycles),
//   flush_cnt (taken branches acted on).
module hazard_ctrl
    import pa_risc_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam bit         HAS_WAIT  = (MEM_LAT > 1);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(MEM_LAT - 2) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       freeze;
    logic       load_use;
    logic [1:0] fwd_a_w, fwd_b_w;

    fwd_sel u_fwd_a (
        .rs        (hif.id_rs1),
        .rs_used   (hif.id_rs1_used),
        .ex_rd     (hif.ex_rd),
        .ex_rf_le  (hif.ex_rf_le),
        .ex_l      (hif.ex_l),
        .mem_rd    (hif.mem_rd),
        .mem_rf_le (hif.mem_rf_le),
        .wb_rd     (hif.wb_rd),
        .wb_rf_le  (hif.wb_rf_le),
        .sel       (fwd_a_w)
    );

    fwd_sel u_fwd_b (
        .rs        (hif.id_rs2),
        .rs_used   (hif.id_rs2_used),
        .ex_rd     (hif.ex_rd),
        .ex_rf_le  (hif.ex_rf_le),
        .ex_l      (hif.ex_l),
        .mem_rd    (hif.mem_rd),
        .mem_rf_le (hif.mem_rf_le),
        .wb_rd     (hif.wb_rd),
        .wb_rf_le  (hif.wb_rf_le),
        .sel       (fwd_b_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first frozen cycle comes combinationally from RUN. MEM_WAIT freezes
    // while the counter is non-zero; its counter==0 cycle is the release cycle:
    // the pipeline advances, pending branch/load-use is acted on, and the
    // still-asserted mem_req of the finishing access is not re-sampled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (hif.mem_req && HAS_WAIT) begin
                    freeze    = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    cnt_nxt   = WAIT_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    freeze  = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign load_use = hif.ex_l && hif.ex_rf_le && (hif.ex_rd != REG_ZERO) &&
                      ((hif.id_rs1_used && hif.id_rs1 == hif.ex_rd) ||
                       (hif.id_rs2_used && hif.id_rs2 == hif.ex_rd));

    // Priority: memory freeze > taken branch > load-use bubble.
    always_comb begin
        hif.fwd_a     = FWD_RF;
        hif.fwd_b     = FWD_RF;
        hif.pc_le     = 1'b1;
        hif.ifid_le   = 1'b1;
        hif.pipe_le   = 1'b1;
        hif.ifid_clr  = 1'b0;
        hif.id_nop    = 1'b0;
        hif.pc_sel_ta = 1'b0;
        if (reset) begin
            hif.fwd_a = fwd_a_w;
            hif.fwd_b = fwd_b_w;
            if (freeze) begin
                hif.pc_le   = 1'b0;
                hif.ifid_le = 1'b0;
                hif.pipe_le = 1'b0;
            end else if (hif.ex_br_taken) begin
                hif.pc_sel_ta = 1'b1;
                hif.ifid_clr  = 1'b1;
                hif.id_nop    = hif.ex_nullify;
            end else if (load_use) begin
                hif.pc_le   = 1'b0;
                hif.ifid_le = 1'b0;
                hif.id_nop  = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_ev, flush_ev;
    assign flush_ev = !freeze && hif.ex_br_taken;
    assign stall_ev = !freeze && !hif.ex_br_taken && load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall_ev && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (freeze && freeze_cnt != '1)
                freeze_cnt <= freeze_cnt + 1'b1;
            if (flush_ev && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances (MEM_LAT = 1, 3, 4)
// see identical stimulus and are compared against a behavioural model that
// tracks each instance's outstanding frozen-cycle budget.
module tb_hazard_ctrl;
    import pa_risc_pkg::*;

    localparam int LATS [3] = '{1, 3, 4};
    // {fwd_a, fwd_b, pc_le, ifid_le, ifid_clr, id_nop, pipe_le, pc_sel_ta}
    localparam logic [9:0] RST_OUT = 10'b00_00_110010;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rd;
        logic       ex_rf_le;
        logic       ex_l;
        logic [4:0] mem_rd;
        logic       mem_rf_le;
        logic [4:0] wb_rd;
        logic       wb_rf_le;
        logic       mem_req;
        logic       ex_br_taken;
        logic       ex_nullify;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    stim_t      stim = '0;
    logic [9:0] got [3];
    int         busy [3];
    bit         ign  [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if ifc [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ifc[g].id_rs1      = stim.id_rs1;
        assign ifc[g].id_rs2      = stim.id_rs2;
        assign ifc[g].id_rs1_used = stim.id_rs1_used;
        assign ifc[g].id_rs2_used = stim.id_rs2_used;
        assign ifc[g].ex_rd       = stim.ex_rd;
        assign ifc[g].ex_rf_le    = stim.ex_rf_le;
        assign ifc[g].ex_l        = stim.ex_l;
        assign ifc[g].mem_rd      = stim.mem_rd;
        assign ifc[g].mem_rf_le   = stim.mem_rf_le;
        assign ifc[g].wb_rd       = stim.wb_rd;
        assign ifc[g].wb_rf_le    = stim.wb_rf_le;
        assign ifc[g].mem_req     = stim.mem_req;
        assign ifc[g].ex_br_taken = stim.ex_br_taken;
        assign ifc[g].ex_nullify  = stim.ex_nullify;
        assign got[g] = {ifc[g].fwd_a, ifc[g].fwd_b, ifc[g].pc_le, ifc[g].ifid_le,
                         ifc[g].ifid_clr, ifc[g].id_nop, ifc[g].pipe_le, ifc[g].pc_sel_ta};

        hazard_ctrl #(.MEM_LAT(LATS[g]), .CNT_W(16)) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .hif   (ifc[g])
        );
    end

    // Reference model: forwarding from a priority list of producers.
    function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic used);
        logic [4:0] rd [3];
        logic       wr [3];
        rd = '{stim.ex_rd, stim.mem_rd, stim.wb_rd};
        wr = '{stim.ex_rf_le && !stim.ex_l, stim.mem_rf_le, stim.wb_rf_le};
        if (!used || rs == 5'd0) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (wr[k] && rd[k] == rs) return 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic logic [9:0] exp_out(int g);
        logic [1:0] fa, fb;
        logic       frz, lu;
        logic [5:0] c;
        if (!rst_n) return RST_OUT;
        fa  = ref_fwd(stim.id_rs1, stim.id_rs1_used);
        fb  = ref_fwd(stim.id_rs2, stim.id_rs2_used);
        frz = (busy[g] > 0) || (!ign[g] && stim.mem_req && LATS[g] > 1);
        lu  = stim.ex_l && stim.ex_rf_le && stim.ex_rd != 5'd0 &&
              ((stim.id_rs1_used && stim.id_rs1 == stim.ex_rd) ||
               (stim.id_rs2_used && stim.id_rs2 == stim.ex_rd));
        if (frz)                   c = 6'b000000;
        else if (stim.ex_br_taken) c = {4'b1110 | {3'b000, stim.ex_nullify}, 2'b11};
        else if (lu)               c = 6'b000110;
        else                       c = 6'b110010;
        return {fa, fb, c};
    endfunction

    // Model state: frozen cycles still owed by the current RAM access, and
    // whether this cycle is the release cycle that ignores mem_req.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 3; g++) begin
                busy[g] <= 0;
                ign[g]  <= 1'b0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (busy[g] > 0) begin
                    busy[g] <= busy[g] - 1;
                    ign[g]  <= (busy[g] == 1);
                end else if (!ign[g] && stim.mem_req && LATS[g] > 1) begin
                    busy[g] <= LATS[g] - 2;
                    ign[g]  <= (LATS[g] == 2);
                end else begin
                    busy[g] <= 0;
                    ign[g]  <= 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t rand_stim(int mem_pct);
        stim_t s;
        s.id_rs1      = 5'($urandom_range(0, 3));
        s.id_rs2      = 5'($urandom_range(0, 3));
        s.id_rs1_used = 1'($urandom);
        s.id_rs2_used = 1'($urandom);
        s.ex_rd       = 5'($urandom_range(0, 3));
        s.ex_rf_le    = 1'($urandom);
        s.ex_l        = 1'($urandom);
        s.mem_rd      = 5'($urandom_range(0, 3));
        s.mem_rf_le   = 1'($urandom);
        s.wb_rd       = 5'($urandom_range(0, 3));
        s.wb_rf_le    = 1'($urandom);
        s.mem_req     = ($urandom_range(0, 99) < mem_pct);
        s.ex_br_taken = ($urandom_range(0, 4) == 0);
        s.ex_nullify  = 1'($urandom);
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        stim  = rand_stim(100);
        #2;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g] !== RST_OUT) begin
                errors++;
                $display("FAIL reset L%0d: got %b expected %b", LATS[g], got[g], RST_OUT);
            end
        end
        stim = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        // ADD r3 in EX, ADD reading r3 in ID
        cyc();
        stim = '0;
        stim.ex_rd = 5'd3; stim.ex_rf_le = 1'b1;
        stim.id_rs1 = 5'd3; stim.id_rs1_used = 1'b1;
        stim.wb_rd = 5'd3; stim.wb_rf_le = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g][9:8] !== 2'b01 || got[g][5] !== 1'b1 || got[g] !== exp_out(g)) begin
                errors++;
                $display("FAIL fwd_ex L%0d: got %b expected %b", LATS[g], got[g], exp_out(g));
            end
        end
        // Load writing GR0 in EX, ID reads r0: no forward, no stall
        cyc();
        stim = '0;
        stim.ex_rd = 5'd0; stim.ex_rf_le = 1'b1; stim.ex_l = 1'b1;
        stim.mem_rd = 5'd0; stim.mem_rf_le = 1'b1;
        stim.id_rs1_used = 1'b1; stim.id_rs2_used = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g] !== 10'b00_00_110010) begin
                errors++;
                $display("FAIL gr0 L%0d: got %b expected %b", LATS[g], got[g], 10'b00_00_110010);
            end
        end
    endtask

    task automatic test_load_use();
        cyc();
        stim = '0;
        stim.ex_rd = 5'd5; stim.ex_rf_le = 1'b1; stim.ex_l = 1'b1;
        stim.id_rs2 = 5'd5; stim.id_rs2_used = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g] !== 10'b00_00_000110) begin
                errors++;
                $display("FAIL load_use L%0d: got %b expected %b", LATS[g], got[g], 10'b00_00_000110);
            end
        end
        // bubble inserted: load now in MEM, SUB still in ID
        cyc();
        stim = '0;
        stim.mem_rd = 5'd5; stim.mem_rf_le = 1'b1;
        stim.id_rs2 = 5'd5; stim.id_rs2_used = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g] !== 10'b00_10_110010) begin
                errors++;
                $display("FAIL load_use_fwd L%0d: got %b expected %b", LATS[g], got[g], 10'b00_10_110010);
            end
        end
    endtask

    task automatic test_branch();
        for (int n = 0; n < 2; n++) begin
            cyc();
            stim = '0;
            stim.ex_br_taken = 1'b1;
            stim.ex_nullify  = 1'(n);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (got[g][5] !== 1'b1 || got[g][3] !== 1'b1 || got[g][0] !== 1'b1 ||
                    got[g][2] !== 1'(n) || got[g] !== exp_out(g)) begin
                    errors++;
                    $display("FAIL branch_n%0d L%0d: got %b expected %b", n, LATS[g], got[g], exp_out(g));
                end
            end
        end
    endtask

    task automatic test_mem_freeze();
        int frozen [3];
        frozen = '{0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            cyc();
            stim = '0;
            stim.mem_req = (c < 3);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (got[g][1] === 1'b0) frozen[g]++;
                checks++;
                if (got[g] !== exp_out(g)) begin
                    errors++;
                    $display("FAIL freeze L%0d cyc %0d: got %b expected %b", LATS[g], c, got[g], exp_out(g));
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (frozen[g] !== LATS[g] - 1) begin
                errors++;
                $display("FAIL freeze_len L%0d: got %0d expected %0d", LATS[g], frozen[g], LATS[g] - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            cyc();
            stim = '0;
            stim.mem_req = 1'b1;
            stim.ex_br_taken = (c == 1);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (got[g] !== exp_out(g)) begin
                    errors++;
                    $display("FAIL b2b L%0d cyc %0d: got %b expected %b", LATS[g], c, got[g], exp_out(g));
                end
            end
        end
        cyc();
        stim = '0;
        repeat (5) cyc();
    endtask

    task automatic test_reset_mid_wait();
        cyc();
        stim = '0;
        stim.mem_req = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (got[2][1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_frozen L4: got pipe_le %b expected 0", got[2][1]);
        end
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (got[g] !== RST_OUT) begin
                errors++;
                $display("FAIL mid_wait_reset L%0d: got %b expected %b", LATS[g], got[g], RST_OUT);
            end
        end
        stim.mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (got[2] !== 10'b00_00_110010 || got[2] !== exp_out(2)) begin
                errors++;
                $display("FAIL post_reset_stall L4 cyc %0d: got %b expected %b", c, got[2], 10'b00_00_110010);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc();
            stim = rand_stim(15);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (got[g] !== exp_out(g)) begin
                    errors++;
                    $display("FAIL random L%0d cyc %0d: got %b expected %b", LATS[g], i, got[g], exp_out(g));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
